// File: rtl/lpc_host_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : lpc_host_arbiter
// Description : Two-requester round-robin arbiter in front of an LPC host
//               controller. The winning request is latched onto the ctrl_*
//               command fields, LFRAME# is pulsed low for LFRAME_CYCLES, and
//               the host handshake (ready drop, then ready rise) completes
//               the cycle with a done pulse. A stalled handshake ends with
//               an err pulse after TIMEOUT cycles.
// Ports       : clk_i, rst_i            clock, synchronous active-high reset
//               req_i/we_i/mem_i [1:0]  per-requester request, write, memory
//               addrN_i [15:0], wdataN_i [7:0]  requester address / data
//               gnt_o, done_o, err_o    one-hot grant, completion, timeout
//               rdata_o [7:0]           read data, valid with done_o
//               ctrl_*_o                command fields to the LPC host
//               ctrl_lframe_o           active-low cycle start
//               ctrl_data_i, ctrl_ready_i  host read data and idle/ready
// Revision    : 1.0 - initial release
// ============================================================================
module lpc_host_arbiter #(
    parameter int LFRAME_CYCLES = 2,
    parameter int TIMEOUT       = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [1:0]  req_i,
    input  logic [1:0]  we_i,
    input  logic [1:0]  mem_i,
    input  logic [15:0] addr0_i,
    input  logic [15:0] addr1_i,
    input  logic [7:0]  wdata0_i,
    input  logic [7:0]  wdata1_i,
    output logic [1:0]  gnt_o,
    output logic [1:0]  done_o,
    output logic [1:0]  err_o,
    output logic [7:0]  rdata_o,
    output logic [15:0] ctrl_addr_o,
    output logic [7:0]  ctrl_data_o,
    output logic        ctrl_memory_cycle_o,
    output logic        ctrl_rd_status_o,
    output logic        ctrl_wr_status_o,
    output logic        ctrl_lframe_o,
    input  logic [7:0]  ctrl_data_i,
    input  logic        ctrl_ready_i
);

    localparam logic [2:0] c_ST_IDLE      = 3'd0;
    localparam logic [2:0] c_ST_START     = 3'd1;
    localparam logic [2:0] c_ST_WAIT_ACK  = 3'd2;
    localparam logic [2:0] c_ST_WAIT_DONE = 3'd3;
    localparam logic [2:0] c_ST_RESP      = 3'd4;

    localparam logic [15:0] c_LFRAME_LAST  = 16'(LFRAME_CYCLES - 1);
    localparam logic [15:0] c_TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [15:0] r_cnt;
    logic        r_last;
    logic [1:0]  r_gnt;
    logic [1:0]  r_done;
    logic [1:0]  r_err;
    logic [7:0]  r_rdata;
    logic [15:0] r_addr;
    logic [7:0]  r_data;
    logic        r_mem;
    logic        r_rd;
    logic        r_wr;

    logic        w_win;
    logic [1:0]  w_win_onehot;
    logic        w_grant;
    logic        w_timeout;
    logic        w_complete;

    // With both requesting, the one not granted last wins. r_last resets to 1
    // so requester 0 is favoured first.
    assign w_win        = (req_i[0] & req_i[1]) ? ~r_last : req_i[1];
    assign w_win_onehot = w_win ? 2'b10 : 2'b01;

    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        w_timeout   = 1'b0;
        w_complete  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                if ((|req_i) && ctrl_ready_i) begin
                    w_grant     = 1'b1;
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                if (r_cnt == c_LFRAME_LAST) begin
                    w_state_nxt = c_ST_WAIT_ACK;
                end
            end
            c_ST_WAIT_ACK: begin
                // Timeout is checked first so it wins over a ready change.
                if (r_cnt == c_TIMEOUT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else if (!ctrl_ready_i) begin
                    w_state_nxt = c_ST_WAIT_DONE;
                end
            end
            c_ST_WAIT_DONE: begin
                if (r_cnt == c_TIMEOUT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
                end else if (ctrl_ready_i) begin
                    w_complete  = 1'b1;
                    w_state_nxt = c_ST_RESP;
                end
            end
            c_ST_RESP: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
            r_gnt   <= '0;
            r_done  <= '0;
            r_err   <= '0;
            r_rdata <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_mem   <= 1'b0;
            r_rd    <= 1'b0;
            r_wr    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= '0;
            r_err   <= '0;

            // One counter serves the LFRAME# length and the handshake
            // timeout: it restarts on every state entry. On a timeout it
            // steps once more so it lands on TIMEOUT.
            if (w_timeout) begin
                r_cnt <= r_cnt + 16'd1;
            end else if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (r_state != c_ST_IDLE) begin
                r_cnt <= r_cnt + 16'd1;
            end

            if (w_grant) begin
                r_gnt  <= w_win_onehot;
                r_last <= w_win;
                r_addr <= w_win ? addr1_i : addr0_i;
                r_data <= w_win ? wdata1_i : wdata0_i;
                r_mem  <= mem_i[w_win];
                r_wr   <= we_i[w_win];
                r_rd   <= ~we_i[w_win];
            end

            if (w_complete) begin
                r_done <= r_gnt;
                if (!r_wr) begin
                    r_rdata <= ctrl_data_i;
                end
            end

            if (w_timeout || (r_state == c_ST_RESP)) begin
                r_err <= w_timeout ? r_gnt : 2'b00;
                r_gnt <= '0;
                r_rd  <= 1'b0;
                r_wr  <= 1'b0;
            end
        end
    end

    assign gnt_o               = r_gnt;
    assign done_o              = r_done;
    assign err_o               = r_err;
    assign rdata_o             = r_rdata;
    assign ctrl_addr_o         = r_addr;
    assign ctrl_data_o         = r_data;
    assign ctrl_memory_cycle_o = r_mem;
    assign ctrl_rd_status_o    = r_rd;
    assign ctrl_wr_status_o    = r_wr;
    assign ctrl_lframe_o       = (r_state != c_ST_START);

endmodule
`default_nettype wire

// File: tb/tb_lpc_host_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_lpc_host_arbiter
// Description : Directed self-checking bench for lpc_host_arbiter. A default
//               instance covers the normal flows; a second instance with
//               TIMEOUT=8 shares the inputs and covers the timeout paths.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lpc_host_arbiter;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  we;
    logic [1:0]  mem;
    logic [15:0] addr0;
    logic [15:0] addr1;
    logic [7:0]  wdata0;
    logic [7:0]  wdata1;
    logic [7:0]  hdata;
    logic        ready;

    logic [1:0]  gnt, done, err;
    logic [7:0]  rdata, c_data;
    logic [15:0] c_addr;
    logic        c_mem, c_rd, c_wr, lframe;

    logic [1:0]  t_gnt, t_done, t_err;
    logic [7:0]  t_rdata, t_c_data;
    logic [15:0] t_c_addr;
    logic        t_c_mem, t_c_rd, t_c_wr, t_lframe;

    int n_pass;
    int n_total;

    lpc_host_arbiter dut (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .mem_i(mem),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .gnt_o(gnt), .done_o(done), .err_o(err), .rdata_o(rdata),
        .ctrl_addr_o(c_addr), .ctrl_data_o(c_data),
        .ctrl_memory_cycle_o(c_mem), .ctrl_rd_status_o(c_rd),
        .ctrl_wr_status_o(c_wr), .ctrl_lframe_o(lframe),
        .ctrl_data_i(hdata), .ctrl_ready_i(ready)
    );

    lpc_host_arbiter #(.LFRAME_CYCLES(2), .TIMEOUT(8)) dut_to (
        .clk_i(clk), .rst_i(rst), .req_i(req), .we_i(we), .mem_i(mem),
        .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
        .gnt_o(t_gnt), .done_o(t_done), .err_o(t_err), .rdata_o(t_rdata),
        .ctrl_addr_o(t_c_addr), .ctrl_data_o(t_c_data),
        .ctrl_memory_cycle_o(t_c_mem), .ctrl_rd_status_o(t_c_rd),
        .ctrl_wr_status_o(t_c_wr), .ctrl_lframe_o(t_lframe),
        .ctrl_data_i(hdata), .ctrl_ready_i(ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst   = 1'b1;
        req   = 2'b00;
        we    = 2'b00;
        mem   = 2'b00;
        ready = 1'b1;
        hdata = 8'h00;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        logic [41:0] obs;
        rst = 1'b1; req = 2'b11; we = 2'b11; mem = 2'b11; ready = 1'b1;
        addr0 = 16'hFFFF; addr1 = 16'hEEEE; wdata0 = 8'hFF; wdata1 = 8'hEE;
        hdata = 8'h00;
        tick();
        tick();
        obs = {gnt, done, err, rdata, c_addr, c_data, lframe, c_rd, c_wr, c_mem};
        n_total++;
        if (obs !== {6'b0, 8'h00, 16'h0000, 8'h00, 1'b1, 3'b000})
            $display("FAIL reset_state: got %h expected %h", obs,
                     {6'b0, 8'h00, 16'h0000, 8'h00, 1'b1, 3'b000});
        else n_pass++;
        n_total++;
        if ({t_gnt, t_err, t_lframe} !== 5'b00001)
            $display("FAIL reset_state_to: got %b expected 00001", {t_gnt, t_err, t_lframe});
        else n_pass++;
        req = 2'b00;
        rst = 1'b0;
    endtask

    task automatic test_single_write;
        int seen;
        do_reset();
        addr0 = 16'hF0F0; wdata0 = 8'h5A; we = 2'b01; mem = 2'b00; req = 2'b01;
        tick();
        n_total++;
        if ({gnt, lframe, c_addr, c_data, c_wr, c_rd, c_mem} !== {2'b01, 1'b0, 16'hF0F0, 8'h5A, 3'b100})
            $display("FAIL write_grant: got %h expected %h",
                     {gnt, lframe, c_addr, c_data, c_wr, c_rd, c_mem},
                     {2'b01, 1'b0, 16'hF0F0, 8'h5A, 3'b100});
        else n_pass++;
        req = 2'b00;
        tick();
        n_total++;
        if (lframe !== 1'b0) $display("FAIL write_lframe_2nd: got %b expected 0", lframe);
        else n_pass++;
        tick();
        n_total++;
        if (lframe !== 1'b1) $display("FAIL write_lframe_release: got %b expected 1", lframe);
        else n_pass++;
        tick();
        ready = 1'b0;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done != 2'b00 || err != 2'b00 || gnt != 2'b01 || c_wr != 1'b1) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL write_busy_hold: got %0d bad cycles expected 0", seen);
        else n_pass++;
        ready = 1'b1;
        tick();
        n_total++;
        if (done !== 2'b01) $display("FAIL write_done: got %b expected 01", done);
        else n_pass++;
        tick();
        n_total++;
        if ({done, gnt, c_wr, c_rd} !== 6'b0) $display("FAIL write_end: got %b expected 000000", {done, gnt, c_wr, c_rd});
        else n_pass++;
    endtask

    task automatic test_single_read;
        do_reset();
        addr1 = 16'h0010; we = 2'b00; mem = 2'b10; req = 2'b10; hdata = 8'h00;
        tick();
        n_total++;
        if ({gnt, c_addr, c_mem, c_rd, c_wr} !== {2'b10, 16'h0010, 3'b110})
            $display("FAIL read_grant: got %h expected %h", {gnt, c_addr, c_mem, c_rd, c_wr}, {2'b10, 16'h0010, 3'b110});
        else n_pass++;
        req = 2'b00;
        tick();
        tick();
        ready = 1'b0;
        tick();
        tick();
        tick();
        n_total++;
        if ({c_mem, rdata, done} !== {1'b1, 8'h00, 2'b00})
            $display("FAIL read_wait: got %h expected %h", {c_mem, rdata, done}, {1'b1, 8'h00, 2'b00});
        else n_pass++;
        hdata = 8'hA5;
        ready = 1'b1;
        tick();
        n_total++;
        if ({done, rdata} !== {2'b10, 8'hA5}) $display("FAIL read_done: got %h expected %h", {done, rdata}, {2'b10, 8'hA5});
        else n_pass++;
        hdata = 8'h3C;
        tick();
        n_total++;
        if ({done, rdata} !== {2'b00, 8'hA5}) $display("FAIL read_hold: got %h expected %h", {done, rdata}, {2'b00, 8'hA5});
        else n_pass++;
    endtask

    task automatic test_contention;
        logic [1:0] exp_order [4];
        int k;
        exp_order[0] = 2'b01; exp_order[1] = 2'b10;
        exp_order[2] = 2'b01; exp_order[3] = 2'b10;
        do_reset();
        addr0 = 16'h1000; addr1 = 16'h2000; we = 2'b00; req = 2'b11;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            while (gnt == 2'b00 && k < 10) begin tick(); k++; end
            n_total++;
            if (gnt !== exp_order[i]) $display("FAIL contention_grant%0d: got %b expected %b", i, gnt, exp_order[i]);
            else n_pass++;
            k = 0;
            while (lframe == 1'b0 && k < 10) begin tick(); k++; end
            ready = 1'b0;
            tick();
            tick();
            ready = 1'b1;
            k = 0;
            while (done == 2'b00 && k < 10) begin tick(); k++; end
            n_total++;
            if (done !== exp_order[i]) $display("FAIL contention_done%0d: got %b expected %b", i, done, exp_order[i]);
            else n_pass++;
            tick();
            n_total++;
            if (gnt !== 2'b00) $display("FAIL contention_idle%0d: got %b expected 00", i, gnt);
            else n_pass++;
        end
        req = 2'b00;
    endtask

    task automatic test_timeout;
        int n;
        int seen;
        do_reset();
        we = 2'b01; mem = 2'b00; req = 2'b01; ready = 1'b1; hdata = 8'h77;
        tick();
        tick();
        tick();
        n_total++;
        if ({t_gnt, t_lframe} !== 3'b011) $display("FAIL timeout_wait_ack: got %b expected 011", {t_gnt, t_lframe});
        else n_pass++;
        n = 0;
        seen = 0;
        while (t_err == 2'b00 && n < 20) begin
            tick();
            n++;
            if (t_done != 2'b00) seen++;
        end
        n_total++;
        if (n !== 8) $display("FAIL timeout_latency: got %0d cycles expected 8", n);
        else n_pass++;
        n_total++;
        if ({t_err, t_done, t_gnt, t_c_wr, t_lframe} !== {2'b01, 2'b00, 2'b00, 2'b01} || seen != 0)
            $display("FAIL timeout_pulse: got %b done_seen %0d expected 01000001", {t_err, t_done, t_gnt, t_c_wr, t_lframe}, seen);
        else n_pass++;
        // Request still pending: an idle FSM grants again on the next edge.
        we = 2'b00;
        tick();
        n_total++;
        if ({t_err, t_gnt, t_c_rd, t_lframe} !== 6'b000110) $display("FAIL timeout_regrant: got %b expected 000110", {t_err, t_gnt, t_c_rd, t_lframe});
        else n_pass++;
        tick();
        tick();
        ready = 1'b0;
        tick();
        seen = 0;
        for (int i = 0; i < 7; i++) begin
            tick();
            if (t_err != 2'b00 || t_done != 2'b00) seen++;
        end
        n_total++;
        if (seen !== 0) $display("FAIL timeout_early: got %0d pulses expected 0", seen);
        else n_pass++;
        ready = 1'b1;
        tick();
        n_total++;
        if ({t_err, t_done, t_rdata, t_gnt} !== {2'b01, 2'b00, 8'h00, 2'b00})
            $display("FAIL timeout_priority: got %h expected %h", {t_err, t_done, t_rdata, t_gnt}, {2'b01, 2'b00, 8'h00, 2'b00});
        else n_pass++;
        req = 2'b00;
    endtask

    task automatic test_reset_mid;
        do_reset();
        addr0 = 16'hABCD; we = 2'b00; mem = 2'b01; req = 2'b01;
        tick();
        tick();
        tick();
        ready = 1'b0;
        tick();
        tick();
        rst = 1'b1; ready = 1'b1; hdata = 8'h99;
        tick();
        n_total++;
        if ({gnt, done, err, rdata, c_addr, c_data, lframe, c_rd, c_wr, c_mem} !== {6'b0, 8'h00, 16'h0000, 8'h00, 1'b1, 3'b000})
            $display("FAIL reset_mid_state: got %h expected %h",
                     {gnt, done, err, rdata, c_addr, c_data, lframe, c_rd, c_wr, c_mem},
                     {6'b0, 8'h00, 16'h0000, 8'h00, 1'b1, 3'b000});
        else n_pass++;
        req = 2'b00;
        rst = 1'b0;
        tick();
        n_total++;
        if ({done, err} !== 4'b0000) $display("FAIL reset_mid_no_pulse: got %b expected 0000", {done, err});
        else n_pass++;
        req = 2'b01;
        tick();
        n_total++;
        if ({gnt, lframe, c_addr} !== {2'b01, 1'b0, 16'hABCD}) $display("FAIL reset_mid_restart: got %h expected %h", {gnt, lframe, c_addr}, {2'b01, 1'b0, 16'hABCD});
        else n_pass++;
        req = 2'b00;
    endtask

    task automatic test_host_busy;
        int bad;
        do_reset();
        ready = 1'b0; we = 2'b01; req = 2'b01;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ({gnt, lframe} != 3'b001) bad++;
        end
        n_total++;
        if (bad !== 0) $display("FAIL host_busy_hold: got %0d bad cycles expected 0", bad);
        else n_pass++;
        ready = 1'b1;
        tick();
        n_total++;
        if ({gnt, lframe} !== 3'b010) $display("FAIL host_busy_release: got %b expected 010", {gnt, lframe});
        else n_pass++;
        req = 2'b00;
        do_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1; req = 2'b00; we = 2'b00; mem = 2'b00; ready = 1'b1;
        addr0 = 16'h0; addr1 = 16'h0; wdata0 = 8'h0; wdata1 = 8'h0; hdata = 8'h0;
        test_reset();
        test_single_write();
        test_single_read();
        test_contention();
        test_timeout();
        test_reset_mid();
        test_host_busy();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
